// File: rtl/dds_wave_lut.sv
// dds_wave_lut -- phase-to-amplitude stage of the DDS chain.
//
// Turns each phase code from the accumulator into an unsigned offset-binary
// sample. Four waveforms are available: a symmetry-folded quarter-wave sine
// LUT, square, triangle and sawtooth. Every waveform goes through the same
// pipeline, so latency does not depend on wave_sel (3 cycles, or 4 when
// DDS_AMP_SCALE_EN adds the amplitude stage).
//
// Optional feature macro: DDS_AMP_SCALE_EN (adds the amp port and stage S4).
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   phase_in   in   PHASE_W  phase code from the accumulator
//   phase_vld  in   1        phase_in / wave_sel (/ amp) valid this cycle
//   wave_sel   in   2        00 sine, 01 square, 10 triangle, 11 sawtooth
//   amp        in   8        amplitude scale, 256 = unity (DDS_AMP_SCALE_EN only)
//   wave_out   out  DATA_W   sample, offset binary; holds while wave_vld = 0
//   wave_vld   out  1        wave_out updated this cycle
module dds_wave_lut #(
    parameter int PHASE_W = 11,
    parameter int DATA_W  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               phase_vld,
    input  logic [1:0]         wave_sel,
`ifdef DDS_AMP_SCALE_EN
    input  logic [7:0]         amp,
`endif
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_vld
);

    localparam int IDX_W = PHASE_W - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam int MAG_W = DATA_W - 1;
    localparam int MID   = 1 << (DATA_W - 1);
    localparam logic [DATA_W-1:0] MID_V  = DATA_W'(MID);
    localparam logic [DATA_W-1:0] MID_M1 = DATA_W'(MID - 1);

    // pi/2 in Q40 fixed point
    localparam longint PIH_Q40 = 64'sd1727108826179;

    // Quarter-wave table entry round((MID-1) * sin(pi/2 * (i+0.5) / DEPTH)),
    // evaluated at elaboration with a Q30 Taylor series (error far below 1 LSB).
    function automatic logic [MAG_W-1:0] sine_mag(input int i);
        longint x;
        longint term;
        longint acc;
        longint scaled;
        x    = (PIH_Q40 * longint'(2 * i + 1)) >>> (IDX_W + 11);
        term = x;
        acc  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        scaled = (longint'(MID - 1) * acc + (longint'(1) <<< 29)) >>> 30;
        return MAG_W'(scaled);
    endfunction

    // Output formation from the delayed phase, selector and LUT magnitude.
    function automatic logic [DATA_W-1:0] form_sample(input logic [1:0]         sel,
                                                      input logic [PHASE_W-1:0] ph,
                                                      input logic [MAG_W-1:0]   mag);
        logic [PHASE_W-2:0] t;
        logic [DATA_W-1:0]  r;
        t = ph[PHASE_W-1] ? ~ph[PHASE_W-2:0] : ph[PHASE_W-2:0];
        case (sel)
            2'b00:   r = ph[PHASE_W-1] ? (MID_M1 - DATA_W'(mag)) : (MID_V + DATA_W'(mag));
            2'b01:   r = {DATA_W{~ph[PHASE_W-1]}};
            2'b10:   r = t[PHASE_W-2 -: DATA_W];
            default: r = ph[PHASE_W-1 -: DATA_W];
        endcase
        return r;
    endfunction

`ifdef DDS_AMP_SCALE_EN
    // MID + floor((s - MID) * a / 256); magnitude never grows, so no saturation needed.
    function automatic logic [DATA_W-1:0] scale_amp(input logic [DATA_W-1:0] s,
                                                    input logic [7:0]        a);
        logic signed [DATA_W:0]   d;
        logic signed [DATA_W+9:0] d_w;
        logic signed [DATA_W+9:0] a_w;
        logic signed [DATA_W+9:0] r;
        d   = $signed({1'b0, s}) - $signed((DATA_W + 1)'(MID));
        d_w = (DATA_W + 10)'(d);
        a_w = (DATA_W + 10)'($signed({1'b0, a}));
        r   = $signed((DATA_W + 10)'(MID)) + ((d_w * a_w) >>> 8);
        return r[DATA_W-1:0];
    endfunction
`endif

    logic [MAG_W-1:0] lut [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_lut
        localparam logic [MAG_W-1:0] ENTRY = sine_mag(g);
        assign lut[g] = ENTRY;
    end

    logic [IDX_W-1:0]   idx_d;
    logic [PHASE_W-1:0] phase_p1_q, phase_p2_q;
    logic [1:0]         sel_p1_q, sel_p2_q;
    logic [IDX_W-1:0]   idx_p1_q;
    logic [MAG_W-1:0]   mag_p2_q;
    logic               vld_p1_q, vld_p2_q, vld_p3_q;
    logic [DATA_W-1:0]  wave_p3_q;
    logic [DATA_W-1:0]  wave_p3_d;

    // Quadrants 01 and 11 run the quarter wave backwards.
    assign idx_d     = phase_in[PHASE_W-2] ? ~phase_in[IDX_W-1:0] : phase_in[IDX_W-1:0];
    assign wave_p3_d = form_sample(sel_p2_q, phase_p2_q, mag_p2_q);

`ifdef DDS_AMP_SCALE_EN
    logic [7:0]        amp_p1_q, amp_p2_q, amp_p3_q;
    logic              vld_p4_q;
    logic [DATA_W-1:0] wave_p4_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            wave_p3_q <= MID_V;
`ifdef DDS_AMP_SCALE_EN
            vld_p4_q  <= 1'b0;
            wave_p4_q <= MID_V;
`endif
        end else begin
            vld_p1_q <= phase_vld;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
                wave_p3_q <= wave_p3_d;
            end
`ifdef DDS_AMP_SCALE_EN
            vld_p4_q <= vld_p3_q;
            if (vld_p3_q) begin
                wave_p4_q <= scale_amp(wave_p3_q, amp_p3_q);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        // S1: capture phase/selector, fold index
        if (phase_vld) begin
            phase_p1_q <= phase_in;
            sel_p1_q   <= wave_sel;
            idx_p1_q   <= idx_d;
`ifdef DDS_AMP_SCALE_EN
            amp_p1_q   <= amp;
`endif
        end
        // S2: registered LUT read, side-band delayed alongside
        mag_p2_q   <= lut[idx_p1_q];
        phase_p2_q <= phase_p1_q;
        sel_p2_q   <= sel_p1_q;
`ifdef DDS_AMP_SCALE_EN
        amp_p2_q   <= amp_p1_q;
        // S3 -> S4: amplitude follows its sample
        amp_p3_q   <= amp_p2_q;
`endif
    end

`ifdef DDS_AMP_SCALE_EN
    assign wave_out = wave_p4_q;
    assign wave_vld = vld_p4_q;
`else
    assign wave_out = wave_p3_q;
    assign wave_vld = vld_p3_q;
`endif

endmodule

// File: tb/tb_dds_wave_lut.sv
// Testbench for dds_wave_lut: directed steps plus random traffic, checked
// against a behavioural model (real-valued sine, delay-line valid model).
module tb_dds_wave_lut;

    localparam int PW    = 11;
    localparam int DW    = 10;
    localparam int MID   = 1 << (DW - 1);
    localparam int FULL  = 1 << PW;
    localparam int HALF  = FULL / 2;
    localparam int QUART = FULL / 4;
`ifdef DDS_AMP_SCALE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam real PI = 3.14159265358979323846;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] phase_in;
    logic          phase_vld;
    logic [1:0]    wave_sel;
`ifdef DDS_AMP_SCALE_EN
    logic [7:0]    amp;
`endif
    logic [DW-1:0] wave_out;
    logic          wave_vld;

    dds_wave_lut #(.PHASE_W(PW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase_in  (phase_in),
        .phase_vld (phase_vld),
        .wave_sel  (wave_sel),
`ifdef DDS_AMP_SCALE_EN
        .amp       (amp),
`endif
        .wave_out  (wave_out),
        .wave_vld  (wave_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int val;
    } ent_t;

    ent_t pipe[$];
    int   held;
    bit   exp_vld;
    int   got[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int exp_wave(int p, int s, int a);
        int  base;
        int  qd, k, ii, mag;
        case (s)
            0: begin
                qd   = p / QUART;
                k    = p % QUART;
                ii   = (qd % 2 == 1) ? (QUART - 1 - k) : k;
                mag  = int'($floor((MID - 1) * $sin(PI / 2.0 * (ii + 0.5) / QUART) + 0.5));
                base = (qd < 2) ? (MID + mag) : (MID - 1 - mag);
            end
            1:       base = (p < HALF) ? (2 * MID - 1) : 0;
            2:       base = ((p < HALF) ? p : (FULL - 1 - p)) >> (PW - 1 - DW);
            default: base = p >> (PW - DW);
        endcase
`ifdef DDS_AMP_SCALE_EN
        base = MID + int'($floor(real'((base - MID) * a) / 256.0));
`endif
        return base;
    endfunction

    task automatic model_reset();
        ent_t e;
        e.vld = 1'b0;
        e.val = 0;
        pipe.delete();
        for (int i = 0; i < LAT - 1; i++) pipe.push_back(e);
        held    = MID;
        exp_vld = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, advance one clock, compare against the model.
    task automatic step(input bit v, input int p, input int s, input int a);
        ent_t e;
        phase_vld = v;
        phase_in  = PW'(p);
        wave_sel  = 2'(s);
`ifdef DDS_AMP_SCALE_EN
        amp       = 8'(a);
`endif
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            e.vld = v;
            e.val = v ? exp_wave(p, s, a) : 0;
            pipe.push_back(e);
            e = pipe.pop_front();
            exp_vld = e.vld;
            if (e.vld) held = e.val;
        end
        @(negedge clk);
        chk("wave_vld", 32'(wave_vld), 32'(exp_vld));
        chk("wave_out", 32'(wave_out), 32'(held));
        if (wave_vld === 1'b1) got.push_back(int'(wave_out));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 255);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b1;
        phase_vld = 1'b0;
        phase_in  = '0;
        wave_sel  = 2'b00;
`ifdef DDS_AMP_SCALE_EN
        amp       = 8'd255;
`endif
        model_reset();
        #1 rst_n = 1'b0;

        // Reset held with phase_vld toggling
        for (int i = 0; i < 6; i++) step(i[0], 100 * i, 0, 255);
        rst_n = 1'b1;
        idle(2);

        // Sine directed values
        got.delete();
        step(1'b1, 0, 0, 255);
        step(1'b1, 511, 0, 255);
        step(1'b1, 512, 0, 255);
        step(1'b1, 1024, 0, 255);
        idle(LAT);
`ifndef DDS_AMP_SCALE_EN
        chk("sine_count", 32'(got.size()), 32'd4);
        chk("sine_p0", 32'(got[0]), 32'd513);
        chk("sine_p511", 32'(got[1]), 32'd1023);
        chk("sine_p512", 32'(got[2]), 32'd1023);
        chk("sine_p1024", 32'(got[3]), 32'd510);
`endif

        // Full sine sweep
        got.delete();
        for (int p = 0; p < FULL; p++) step(1'b1, p, 0, 255);
        idle(LAT);
`ifndef DDS_AMP_SCALE_EN
        chk("sweep_count", 32'(got.size()), 32'(FULL));
        if (got.size() == FULL) begin
            for (int p = 0; p < HALF; p++)
                chk("sine_halfwave_sum", 32'(got[p] + got[p + HALF]), 32'(2 * MID - 1));
        end
`endif

        // Square / sawtooth / triangle corners
        got.delete();
        step(1'b1, 1023, 1, 255);
        step(1'b1, 1024, 1, 255);
        step(1'b1, 2047, 3, 255);
        step(1'b1, 1, 3, 255);
        step(1'b1, 0, 2, 255);
        step(1'b1, 1023, 2, 255);
        step(1'b1, 2047, 2, 255);
        idle(LAT);
`ifndef DDS_AMP_SCALE_EN
        chk("shape_count", 32'(got.size()), 32'd7);
        chk("square_1023", 32'(got[0]), 32'd1023);
        chk("square_1024", 32'(got[1]), 32'd0);
        chk("saw_2047", 32'(got[2]), 32'd1023);
        chk("saw_1", 32'(got[3]), 32'd0);
        chk("tri_0", 32'(got[4]), 32'd0);
        chk("tri_1023", 32'(got[5]), 32'd1023);
        chk("tri_2047", 32'(got[6]), 32'd0);
`endif

        // Bubble and selector change mid-stream
        got.delete();
        step(1'b1, 100, 0, 255);
        step(1'b0, 200, 1, 255);
        step(1'b1, 300, 1, 255);
        step(1'b1, 1500, 1, 255);
        idle(LAT);
`ifndef DDS_AMP_SCALE_EN
        chk("bubble_count", 32'(got.size()), 32'd3);
        chk("bubble_sel_s3", 32'(got[1]), 32'd1023);
        chk("bubble_sel_s4", 32'(got[2]), 32'd0);
`endif

        // Reset while samples are in flight
        step(1'b1, 700, 0, 255);
        step(1'b1, 800, 0, 255);
        step(1'b1, 900, 0, 255);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 32'(wave_vld), 32'd0);
        chk("async_rst_out", 32'(wave_out), 32'(MID));
        model_reset();
        step(1'b1, 1000, 2, 255);
        step(1'b0, 0, 0, 255);
        rst_n = 1'b1;
        got.delete();
        step(1'b1, 0, 0, 255);
        idle(LAT);
`ifndef DDS_AMP_SCALE_EN
        chk("post_rst_count", 32'(got.size()), 32'd1);
        chk("post_rst_first", 32'(got[0]), 32'd513);
`endif

`ifdef DDS_AMP_SCALE_EN
        // Amplitude scaling
        got.delete();
        step(1'b1, 511, 0, 128);
        step(1'b1, 511, 0, 0);
        step(1'b1, 511, 0, 255);
        idle(LAT);
        chk("amp_count", 32'(got.size()), 32'd3);
        chk("amp_128", 32'(got[0]), 32'd767);
        chk("amp_0", 32'(got[1]), 32'(MID));
        chk("amp_255", 32'(got[2]), 32'd1021);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, int'($urandom_range(0, FULL - 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end
        idle(LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
